// File: rtl/nn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_pkg                                                               |
// | Shared types and helpers for the classifier tail stages.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nn_pkg;

  localparam int NN_T_DEFAULT = 16;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } nn_argmax_state_t;

  // Clamped at 1 so a degenerate M never yields a zero-width index.
  function automatic int NN_IDX_W(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_argmax_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_argmax_stage                                                      |
// | Streaming argmax over M signed activations per vector; emits the    |
// | index and value of the maximum. Option: NN_ARGMAX_OVERLAP_EN.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nn_argmax_stage
  import nn_pkg::*;
#(
  parameter  int M  = 8,
  parameter  int T  = NN_T_DEFAULT,
  localparam int IW = NN_IDX_W(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [T-1:0]  data_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [IW-1:0] m_index,
  output logic [T-1:0]  m_value
);

  localparam logic [IW-1:0] c_last = IW'(M - 1);

  nn_argmax_state_t r_state;
  nn_argmax_state_t w_state_nxt;

  logic [IW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [T-1:0]  r_max;

  logic          w_accept;
  logic          w_last;
  logic          w_first;
  logic          w_gt;
  logic [T-1:0]  w_max_nxt;
  logic [IW-1:0] w_idx_nxt;

`ifdef NN_ARGMAX_OVERLAP_EN
  logic [IW-1:0] r_res_idx;
  logic [T-1:0]  r_res_val;
`endif

  // Strict greater-than keeps the earliest index on ties.
  assign w_first   = (r_cnt == '0);
  assign w_gt      = $signed(data_in) > $signed(r_max);
  assign w_max_nxt = (w_first || w_gt) ? data_in : r_max;
  assign w_idx_nxt = w_first ? '0 : (w_gt ? r_cnt : r_idx);

  assign w_accept  = s_valid && s_ready;
  assign w_last    = w_accept && (r_cnt == c_last);
  assign m_valid   = (r_state == HOLD);

`ifdef NN_ARGMAX_OVERLAP_EN
  // Only the closing beat of the next vector has to wait for the result slot.
  assign s_ready = reset && !(m_valid && (r_cnt == c_last));
  assign m_index = r_res_idx;
  assign m_value = r_res_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_idx <= '0;
      r_res_val <= '0;
    end else if (w_last) begin
      r_res_idx <= w_idx_nxt;
      r_res_val <= w_max_nxt;
    end
  end
`else
  // The accumulator doubles as the result register since no beat lands in HOLD.
  assign s_ready = reset && (r_state == ACCUM);
  assign m_index = r_idx;
  assign m_value = r_max;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_max   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_max <= w_max_nxt;
        r_idx <= w_idx_nxt;
        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_last) w_state_nxt = HOLD;
      HOLD:    if (m_ready && !w_last) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

endmodule
`default_nettype wire
